// File: rtl/uart_pkg.sv
// uart_pkg: host protocol byte constants and state encodings shared by the
// bus master and its UART core.
package uart_pkg;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h3F;

   typedef enum logic [2:0] {
      IDLE, ADDR, DATA, BUS_WR, BUS_RD, RD_CAP, TX_LOAD, TX_WAIT
   } state_e;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart.sv
// uart: 8N1 UART core; receiver samples mid-bit, transmitter sends LSB first.
// Reset is asynchronous so the line idles high as soon as rst rises.
module uart
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       is_transmitting,
   output logic       recv_error
);
   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]    sync_q;
   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_clk_q, rx_clk_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic          received_q, received_d, err_q, err_d;
   logic [9:0]    tx_sh_q;
   logic [3:0]    tx_cnt_q;
   logic [CW-1:0] tx_clk_q;
   logic          tx_busy_q;
   logic          rx_s;

   assign rx_s = sync_q[1];

   always_comb begin
      rx_state_d = rx_state_q;
      rx_clk_d   = rx_clk_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      received_d = 1'b0;
      err_d      = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (!rx_s) begin
            rx_state_d = RX_START;
            rx_clk_d   = HALF_LAST;
         end
         RX_START:
            if (rx_clk_q != '0) rx_clk_d = rx_clk_q - 1'b1;
            else if (rx_s) rx_state_d = RX_IDLE;
            else begin
               rx_state_d = RX_DATA;
               rx_clk_d   = BIT_LAST;
               rx_bit_d   = '0;
            end
         RX_DATA:
            if (rx_clk_q != '0) rx_clk_d = rx_clk_q - 1'b1;
            else begin
               rx_sh_d  = {rx_s, rx_sh_q[7:1]};
               rx_clk_d = BIT_LAST;
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         default:
            if (rx_clk_q != '0) rx_clk_d = rx_clk_q - 1'b1;
            else begin
               rx_state_d = RX_IDLE;
               received_d = rx_s;
               err_d      = !rx_s;
            end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= 2'b11;
         rx_state_q <= RX_IDLE;
         rx_clk_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         received_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], rx};
         rx_state_q <= rx_state_d;
         rx_clk_q   <= rx_clk_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         received_q <= received_d;
         err_q      <= err_d;
      end
   end

   // Frame is {stop, data, start}; shifting in ones leaves the line idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sh_q   <= '1;
         tx_cnt_q  <= '0;
         tx_clk_q  <= '0;
         tx_busy_q <= 1'b0;
      end else if (!tx_busy_q) begin
         if (transmit) begin
            tx_sh_q   <= {1'b1, tx_byte, 1'b0};
            tx_cnt_q  <= 4'd9;
            tx_clk_q  <= BIT_LAST;
            tx_busy_q <= 1'b1;
         end
      end else if (tx_clk_q != '0) begin
         tx_clk_q <= tx_clk_q - 1'b1;
      end else if (tx_cnt_q == '0) begin
         tx_busy_q <= 1'b0;
      end else begin
         tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
         tx_cnt_q <= tx_cnt_q - 4'd1;
         tx_clk_q <= BIT_LAST;
      end
   end

   assign tx              = tx_sh_q[0];
   assign received        = received_q;
   assign recv_error      = err_q;
   assign rx_byte         = rx_sh_q;
   assign is_receiving    = rx_state_q != RX_IDLE;
   assign is_transmitting = tx_busy_q;
endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: decodes 'W'/'R' host commands arriving over UART into
// single-cycle bus strobes and returns 'K', '?' or the 4 read bytes.
module uart_bus_master
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CLKS_PER_BIT   = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        serial_in,
   output logic        serial_out,
   output logic [31:0] address,
   output logic        writeenable,
   output logic [31:0] writedata,
   output logic        readenable,
   input  logic [31:0] readdata,
   output logic        busy
);
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic        write_q, write_d, seen_q, seen_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [2:0]  len_q, len_d;
   logic [23:0] timer_q, timer_d;
   logic [31:0] address_q, address_d, writedata_q, writedata_d, reply_q, reply_d;
   logic        transmit, received, is_receiving, is_transmitting, recv_error;
   logic [7:0]  rx_byte;

   uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk             (clk),
      .rst             (!reset_n),
      .rx              (serial_in),
      .tx              (serial_out),
      .transmit        (transmit),
      .tx_byte         (reply_q[31:24]),
      .received        (received),
      .rx_byte         (rx_byte),
      .is_receiving    (is_receiving),
      .is_transmitting (is_transmitting),
      .recv_error      (recv_error)
   );

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      seen_d      = seen_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      timer_d     = timer_q;
      address_d   = address_q;
      writedata_d = writedata_q;
      reply_d     = reply_q;
      transmit    = 1'b0;
      case (state_q)
         IDLE: if (received) begin
            cnt_d   = '0;
            timer_d = '0;
            if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
               write_d = rx_byte == CMD_WRITE;
               state_d = ADDR;
            end else begin
               reply_d = {RSP_ERR, 24'h0};
               len_d   = 3'd1;
               state_d = TX_LOAD;
            end
         end
         ADDR, DATA:
            if (recv_error) state_d = IDLE;
            else if (received) begin
               timer_d = '0;
               cnt_d   = cnt_q + 2'd1;
               if (state_q == ADDR) address_d = {address_q[23:0], rx_byte};
               else writedata_d = {writedata_q[23:0], rx_byte};
               if (cnt_q == 2'd3) state_d = state_q == DATA ? BUS_WR : write_q ? DATA : BUS_RD;
            end
            // A frame already underway is allowed to finish before timing out.
            else if (timer_q >= TMO_LAST && !is_receiving) state_d = IDLE;
            else if (!is_receiving) timer_d = timer_q + 24'd1;
         BUS_WR: begin
            reply_d = {RSP_OK, 24'h0};
            len_d   = 3'd1;
            state_d = TX_LOAD;
         end
         BUS_RD: state_d = RD_CAP;
         RD_CAP: begin
            reply_d = readdata;
            len_d   = 3'd4;
            state_d = TX_LOAD;
         end
         TX_LOAD: if (!is_transmitting) begin
            transmit = 1'b1;
            reply_d  = {reply_q[23:0], 8'h00};
            len_d    = len_q - 3'd1;
            seen_d   = 1'b0;
            state_d  = TX_WAIT;
         end
         default:
            if (is_transmitting) seen_d = 1'b1;
            else if (seen_q) state_d = len_q != '0 ? TX_LOAD : IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         seen_q      <= 1'b0;
         cnt_q       <= '0;
         len_q       <= '0;
         timer_q     <= '0;
         address_q   <= '0;
         writedata_q <= '0;
         reply_q     <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         seen_q      <= seen_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         timer_q     <= timer_d;
         address_q   <= address_d;
         writedata_q <= writedata_d;
         reply_q     <= reply_d;
      end
   end

   assign address     = address_q;
   assign writedata   = writedata_q;
   assign writeenable = state_q == BUS_WR;
   assign readenable  = state_q == BUS_RD;
   assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: host UART driver/decoder plus slave model; each command
// is checked against the reply bytes and strobes the protocol calls for.
module tb_uart_bus_master;
   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        serial_in = 1'b1;
   logic        serial_out, writeenable, readenable, busy;
   logic [31:0] address, writedata;
   logic [31:0] readdata = 32'h0;
   logic [31:0] slave_val = 32'h0;
   logic [7:0]  rxq[$];
   logic [31:0] we_addr[$], we_data[$], re_addr[$];
   int unsigned total = 0, bad = 0, both_cnt = 0, frame_err = 0;
   logic [7:0]  rb;

   uart_bus_master #(.TIMEOUT_CYCLES(1000), .CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .serial_in   (serial_in),
      .serial_out  (serial_out),
      .address     (address),
      .writeenable (writeenable),
      .writedata   (writedata),
      .readenable  (readenable),
      .readdata    (readdata),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Slave: data valid only in the cycle after readenable, junk otherwise.
   always @(posedge clk) readdata <= readenable ? slave_val : 32'hA5A5_5A5A;

   always @(negedge clk) begin
      if (writeenable) begin
         we_addr.push_back(address);
         we_data.push_back(writedata);
      end
      if (readenable) re_addr.push_back(address);
      if (writeenable && readenable) both_cnt++;
   end

   initial forever begin
      @(negedge serial_out);
      repeat (CPB / 2) @(negedge clk);
      if (serial_out === 1'b0) begin
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rb[i] = serial_out;
         end
         repeat (CPB) @(negedge clk);
         if (serial_out !== 1'b1) frame_err++;
         rxq.push_back(rb);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         serial_in = f[i];
         repeat (CPB - 1) @(negedge clk);
      end
   endtask

   task automatic wait_rx(input int n);
      int c;
      c = 0;
      while (rxq.size() < n && c < 5000) begin
         @(negedge clk);
         c++;
      end
      check("reply_count", rxq.size(), n);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (busy !== 1'b0 && c < 5000) begin
         @(negedge clk);
         c++;
      end
      repeat (4) @(negedge clk);
      check("busy_low", busy, 1'b0);
   endtask

   task automatic clear_mon();
      rxq.delete();
      we_addr.delete();
      we_data.delete();
      re_addr.delete();
   endtask

   // Reference: a write yields 'K' and one write strobe, a read yields the
   // four slave bytes MSB first and one read strobe, anything else yields '?'.
   task automatic transact(input logic [7:0] kind, input logic [31:0] a, input logic [31:0] d);
      logic [7:0] cmd[$];
      logic [7:0] exp_rx[$];
      bool_check: begin end
      clear_mon();
      cmd.push_back(kind);
      if (kind == 8'h57 || kind == 8'h52)
         for (int i = 3; i >= 0; i--) cmd.push_back(a[8*i +: 8]);
      if (kind == 8'h57) begin
         for (int i = 3; i >= 0; i--) cmd.push_back(d[8*i +: 8]);
         exp_rx.push_back(8'h4B);
      end else if (kind == 8'h52) begin
         slave_val = d;
         for (int i = 3; i >= 0; i--) exp_rx.push_back(d[8*i +: 8]);
      end else exp_rx.push_back(8'h3F);
      foreach (cmd[i]) send_byte(cmd[i]);
      wait_rx(exp_rx.size());
      wait_idle();
      foreach (exp_rx[i]) check($sformatf("reply_byte%0d", i), rxq.size() > i ? rxq[i] : 8'hxx, exp_rx[i]);
      check("we_count", we_addr.size(), kind == 8'h57 ? 1 : 0);
      check("re_count", re_addr.size(), kind == 8'h52 ? 1 : 0);
      if (we_addr.size() == 1) begin
         check("we_addr", we_addr[0], a);
         check("we_data", we_data[0], d);
      end
      if (re_addr.size() == 1) check("re_addr", re_addr[0], a);
      if (kind == 8'h57 || kind == 8'h52) check("address_hold", address, a);
   endtask

   initial begin
      logic [7:0]  k;
      logic [31:0] ra, rd;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_we", writeenable, 1'b0);
      check("rst_re", readenable, 1'b0);
      check("rst_addr", address, 32'h0);
      check("rst_wdata", writedata, 32'h0);
      check("rst_txline", serial_out, 1'b1);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      transact(8'h57, 32'h0000_1004, 32'hDEAD_BEEF);
      transact(8'h52, 32'h0000_2000, 32'h1234_5678);
      transact(8'h41, 32'h0, 32'h0);

      clear_mon();
      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (2000) @(negedge clk);
      check("timeout_busy", busy, 1'b0);
      check("timeout_we", we_addr.size(), 0);
      check("timeout_reply", rxq.size(), 0);
      transact(8'h52, 32'h0000_0008, 32'h0BAD_CAFE);

      clear_mon();
      send_byte(8'h57);
      for (int i = 0; i < 4; i++) send_byte(8'h11 * (i + 1));
      @(negedge clk);
      serial_in = 1'b0;
      repeat (CPB * 3) @(negedge clk);
      reset_n = 1'b0;
      serial_in = 1'b1;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_addr", address, 32'h0);
      check("midrst_wdata", writedata, 32'h0);
      check("midrst_we", writeenable, 1'b0);
      check("midrst_re", readenable, 1'b0);
      check("midrst_txline", serial_out, 1'b1);
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (CPB * 12) @(negedge clk);
      check("midrst_no_we", we_addr.size(), 0);
      transact(8'h57, 32'hCAFE_F00D, 32'h0102_0304);

      clear_mon();
      slave_val = 32'h89AB_CDEF;
      send_byte(8'h52);
      for (int i = 3; i >= 0; i--) send_byte(8'h30 + 8'(i));
      wait_rx(1);
      send_byte(8'h57);
      send_byte(8'h41);
      wait_rx(4);
      wait_idle();
      repeat (CPB * 24) @(negedge clk);
      check("inject_reply_len", rxq.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("inject_byte%0d", i), rxq.size() > i ? rxq[i] : 8'hxx, slave_val[8*(3-i) +: 8]);
      check("inject_re", re_addr.size(), 1);
      check("inject_we", we_addr.size(), 0);
      check("inject_busy", busy, 1'b0);

      for (int n = 0; n < 6; n++) begin
         ra = $urandom;
         rd = $urandom;
         case ($urandom_range(0, 2))
            0: k = 8'h57;
            1: k = 8'h52;
            default: begin
               k = 8'($urandom_range(0, 255));
               while (k == 8'h57 || k == 8'h52) k = 8'($urandom_range(0, 255));
            end
         endcase
         transact(k, ra, rd);
      end

      check("strobe_overlap", both_cnt, 0);
      check("host_frame_err", frame_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
